// File: rtl/core_ldst_queue_pkg.sv
// Shared load/store types: access size, queue entry, writeback line and byte-lane helpers.
package core_ldst_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_num_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ldst_size_e;

  typedef struct packed {
    logic     ready;
    reg_num_t rd;
    word_t    value;
  } wb_line_t;

  typedef struct packed {
    logic       load;
    ldst_size_e size;
    logic       sgn;
    reg_num_t   rd;
    word_t      addr;
    word_t      data;
  } ldst_entry_t;

  function automatic logic is_aligned(input ldst_size_e size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return !ofs[0];
      default: return ofs == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input ldst_size_e size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: return 4'b0001 << ofs;
      SZ_HALF: return 4'b0011 << ofs;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic word_t lane_wdata(input ldst_size_e size, input word_t d);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Word loads ignore sgn: nothing is left to extend.
  function automatic word_t lane_rdata(input ldst_size_e size, input logic sgn,
                                       input logic [1:0] ofs, input word_t d);
    word_t s;
    s = d >> {ofs, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sgn & s[7]}}, s[7:0]};
      SZ_HALF: return {{16{sgn & s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/core_ldst_fifo.sv
// In-order circular buffer of load/store entries; exposes per-entry valid/load/rd for hazard tracking.
module core_ldst_fifo
  import core_ldst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  ldst_entry_t            push_entry,
  input  logic                   pop,
  output ldst_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       ent_vld,
  output logic [DEPTH-1:0]       ent_load,
  output reg_num_t [DEPTH-1:0]   ent_rd
);

  localparam int PW = $clog2(DEPTH);

  ldst_entry_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    ent_load = '0;
    ent_rd   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_load[i] = mem[i].load;
      ent_rd[i]   = mem[i].rd;
    end
  end

endmodule

// File: rtl/core_ldst_queue.sv
// Load/store unit: queues issued memory ops in order, runs one word-bus transaction at a time,
// aligns/extends load data onto the writeback line and publishes a RAW mask of pending loads.
module core_ldst_queue
  import core_ldst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REGS  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op_load,
  input  logic [1:0]      op_size,
  input  logic            op_signed,
  input  logic [3:0]      op_rd,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            wb_stall,
  input  logic            ldst_ready,
  input  logic [31:0]     ldst_data_rd,
  output logic            ldst_wait,
  output logic            fault,
  output logic [REGS-1:0] raw_mask,
  output logic            ldst_start,
  output logic            ldst_write,
  output logic [29:0]     ldst_addr,
  output logic [3:0]      ldst_be,
  output logic [31:0]     ldst_data_wr,
  output wb_line_t        wb
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} bus_state_e;

  bus_state_e           state;
  bus_state_e           state_nxt;
  ldst_entry_t          in_entry;
  ldst_entry_t          head;
  logic                 full;
  logic                 empty;
  logic                 aligned;
  logic                 push;
  logic                 pop;
  logic                 load_done;
  logic [DEPTH-1:0]     ent_vld;
  logic [DEPTH-1:0]     ent_load;
  reg_num_t [DEPTH-1:0] ent_rd;
  word_t                load_value;
  word_t                res_value;

  assign in_entry = '{load: op_load, size: ldst_size_e'(op_size), sgn: op_signed,
                      rd: op_rd, addr: (op_load ? a : b), data: a};
  assign aligned   = is_aligned(in_entry.size, in_entry.addr[1:0]);
  assign ldst_wait = full;
  assign push      = start && !full && aligned;

  core_ldst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .ent_vld    (ent_vld),
    .ent_load   (ent_load),
    .ent_rd     (ent_rd)
  );

  // The head entry stays queued until retired, so bus fields come straight from it.
  assign ldst_start   = (state == S_REQ);
  assign ldst_write   = !head.load;
  assign ldst_addr    = head.addr[31:2];
  assign ldst_be      = lane_be(head.size, head.addr[1:0]);
  assign ldst_data_wr = lane_wdata(head.size, head.data);
  assign load_value   = lane_rdata(head.size, head.sgn, head.addr[1:0], ldst_data_rd);
  assign load_done    = (state == S_WAIT) && ldst_ready && head.load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // IDLE also looks at this cycle's push so an empty queue requests the bus one cycle later.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (!empty || push) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (ldst_ready) begin
          if (head.load) begin
            state_nxt = S_RESP;
          end else begin
            pop       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (wb.ready && !wb_stall) begin
          pop       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wb only moves on unstalled cycles; a result caught under stall waits in res_value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb        <= '0;
      res_value <= '0;
      fault     <= 1'b0;
    end else begin
      fault <= start && !full && !aligned;
      if (load_done) res_value <= load_value;
      if (!wb_stall) begin
        if (wb.ready)               wb.ready <= 1'b0;
        else if (load_done)         wb <= '{ready: 1'b1, rd: head.rd, value: load_value};
        else if (state == S_RESP)   wb <= '{ready: 1'b1, rd: head.rd, value: res_value};
      end
    end
  end

  always_comb begin
    raw_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_load[i]) raw_mask[ent_rd[i]] = 1'b1;
    end
    if (push && op_load) raw_mask[op_rd] = 1'b1;
  end

endmodule
